// File: rtl/wb_fuzz_master_arbiter_pkg.sv
// Shared types and helpers for the fuzzer external-master arbiter.
package wb_fuzz_pkg;

  typedef enum logic [2:0] {
    A_IDLE,
    A_ISSUE,
    A_WAIT,
    A_RESP,
    A_DRAIN
  } arb_state_t;

  localparam int DEF_TIMEOUT = 1024;
  localparam int TIMER_W     = $clog2(DEF_TIMEOUT) + 1;

  // Wrap-around index used by the round-robin search.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/wb_fuzz_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr wins.
module rr_arbiter
  import wb_fuzz_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   cand;

  // Search from ptr+1 so the previous winner is considered last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = rr_wrap(int'(ptr), k, N);
      if (!found && req[IDX_W'(cand)]) begin
        found             = 1'b1;
        gnt[IDX_W'(cand)] = 1'b1;
        gnt_idx           = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_fuzz_master_arbiter.sv
// Shares the bridge external-master port among NUM_REQ fuzzer sources,
// one burst in flight, with a watchdog on hung bursts.
//
//  state   | meaning
//  A_IDLE  | sample req_valid, grant and latch the winner's request
//  A_ISSUE | pulse br_req, accept pulse to winner, clear watchdog
//  A_WAIT  | hold burst fields, wait for done or watchdog expiry
//  A_RESP  | one-cycle completion pulse to the winner
//  A_DRAIN | after a timeout, swallow the bridge's late done
module wb_fuzz_master_arbiter
  import wb_fuzz_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int EXT_RW_WIDTH = 256,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*EXT_RW_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_err,
  output logic [EXT_RW_WIDTH-1:0]         rsp_rdata,
  output logic                            br_req,
  output logic                            br_we,
  output logic [ADDR_WIDTH-1:0]           br_addr_read,
  output logic [ADDR_WIDTH-1:0]           br_addr_write,
  output logic [EXT_RW_WIDTH-1:0]         br_wdata,
  input  logic [EXT_RW_WIDTH-1:0]         br_rdata,
  input  logic                            br_read_done,
  input  logic                            br_write_done,
  output logic                            busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [EXT_RW_WIDTH-1:0] wdata_q, wdata_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    err_q, err_d;
  logic                    to_q, to_d;
  logic [EXT_RW_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    exp_done, bad_done, hold_drv;
  logic [NUM_REQ-1:0]      win_oh;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // State and hold registers; ptr starts at the last requester so 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: grant, watchdog and completion classification.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    err_d    = err_q;
    to_d     = to_q;
    rdata_d  = rdata_q;
    exp_done = we_q ? br_write_done : br_read_done;
    bad_done = we_q ? br_read_done  : br_write_done;
    case (state_q)
      A_IDLE: begin
        if (|req_valid) begin
          gidx_d  = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = A_ISSUE;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              we_d    = req_we[i];
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*EXT_RW_WIDTH +: EXT_RW_WIDTH];
            end
          end
        end
      end
      A_ISSUE: begin
        timer_d = '0;
        state_d = A_WAIT;
      end
      A_WAIT: begin
        // A matching done beats the watchdog when both land together.
        if (exp_done) begin
          rdata_d = we_q ? '0 : br_rdata;
          err_d   = 1'b0;
          to_d    = 1'b0;
          state_d = A_RESP;
        end else if (bad_done) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b0;
          state_d = A_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = A_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      A_RESP:  state_d = to_q ? A_DRAIN : A_IDLE;
      A_DRAIN: if (br_read_done || br_write_done) state_d = A_IDLE;
      default: state_d = A_IDLE;
    endcase
  end

  // Outputs decoded from state; burst fields are zero outside the burst.
  always_comb begin
    win_oh        = NUM_REQ'(1) << gidx_q;
    hold_drv      = (state_q == A_ISSUE) || (state_q == A_WAIT);
    busy          = (state_q != A_IDLE);
    req_ready     = (state_q == A_ISSUE) ? win_oh : '0;
    br_req        = (state_q == A_ISSUE);
    br_we         = hold_drv & we_q;
    br_addr_read  = hold_drv ? addr_q  : '0;
    br_addr_write = hold_drv ? addr_q  : '0;
    br_wdata      = hold_drv ? wdata_q : '0;
    rsp_valid     = (state_q == A_RESP) ? win_oh : '0;
    rsp_err       = (state_q == A_RESP) & err_q;
    rsp_rdata     = rdata_q;
  end

endmodule

// File: tb/tb_wb_fuzz_master_arbiter.sv
`timescale 1ns/1ps
module tb_wb_fuzz_master_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic            br_req, br_we;
  logic [AW-1:0]   br_addr_read, br_addr_write;
  logic [DW-1:0]   br_wdata, br_rdata;
  logic            br_read_done, br_write_done, busy;

  wb_fuzz_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .EXT_RW_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .br_req(br_req), .br_we(br_we), .br_addr_read(br_addr_read),
    .br_addr_write(br_addr_write), .br_wdata(br_wdata), .br_rdata(br_rdata),
    .br_read_done(br_read_done), .br_write_done(br_write_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct { int idx; bit we; } brq_t;
  typedef struct { int idx; bit err; logic [DW-1:0] rdata; int cyc; bit to; } rsp_t;
  typedef struct { int mode; int dly; bit a5; } plan_t;

  txn_t  rq [N][$];
  brq_t  bq [$];
  rsp_t  sq [$];
  plan_t plan [$];

  int  n_cmp = 0, n_bad = 0, cyc = 0, grant_ok = 0, m_ptr = N - 1, gap_max = 0;
  bit  m_idle = 1'b1, mon_en = 1'b0, drv_en = 1'b0, rsp_en = 1'b0, hold_on = 1'b0;
  txn_t hold_t;
  logic [DW-1:0] last_rdata = '0;
  int  gap [N];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference round-robin rule: first pending requester after the last winner.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[IW'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic txn_t mk(input bit we, input logic [AW-1:0] a);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = rand_wide();
    return t;
  endfunction

  // Requester drivers: present queue heads, advance on accept pulse.
  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] && rq[i].size() > 0) begin
            void'(rq[i].pop_front());
            gap[i] = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
          end else if (gap[i] > 0) gap[i]--;
          if (rq[i].size() > 0 && gap[i] == 0) begin
            req_valid[i] = 1'b1;
            req_we[i] = rq[i][0].we;
            req_addr[i*AW +: AW] = rq[i][0].addr;
            req_wdata[i*DW +: DW] = rq[i][0].wdata;
          end else begin
            req_valid[i] = 1'b0;
            req_we[i] = 1'($urandom);
            req_addr[i*AW +: AW] = (i == 0) ? 32'h0000_DEAD : $urandom;
            req_wdata[i*DW +: DW] = rand_wide();
          end
        end
      end
    end
  end

  // Bridge model: answers each issued burst according to the plan.
  initial begin
    brq_t b; plan_t pl; int i0, target, r;
    br_read_done = 1'b0; br_write_done = 1'b0; br_rdata = '0;
    forever begin
      @(negedge clk);
      br_read_done = 1'b0; br_write_done = 1'b0; br_rdata = rand_wide();
      if (rsp_en && bq.size() > 0) begin
        b = bq.pop_front();
        i0 = cyc;
        if (plan.size() > 0) pl = plan.pop_front();
        else begin
          r = $urandom_range(99, 0);
          pl.a5 = 1'b0;
          pl.mode = (r < 70) ? 0 : (r < 85) ? 1 : 2;
          if (pl.mode == 2) pl.dly = $urandom_range(5, 0);
          else pl.dly = ($urandom_range(9, 0) == 0) ? TO : $urandom_range(5, 1);
        end
        if (pl.mode == 0 && $urandom_range(3, 0) == 0) begin
          if ($urandom_range(1, 0) == 1) br_read_done = 1'b1; else br_write_done = 1'b1;
        end
        if (pl.mode == 2) begin
          sq.push_back('{b.idx, 1'b1, '0, i0 + TO + 1, 1'b1});
          target = i0 + TO + 2 + pl.dly;
        end else target = i0 + pl.dly;
        while (cyc < target) begin
          @(negedge clk);
          br_read_done = 1'b0; br_write_done = 1'b0; br_rdata = rand_wide();
        end
        if (pl.a5) br_rdata = {32{8'hA5}};
        if (pl.mode == 0) begin
          if (b.we) br_write_done = 1'b1; else br_read_done = 1'b1;
          sq.push_back('{b.idx, 1'b0, b.we ? '0 : br_rdata, target + 1, 1'b0});
        end else if (pl.mode == 1) begin
          if (b.we) br_read_done = 1'b1; else br_write_done = 1'b1;
          sq.push_back('{b.idx, 1'b1, '0, target + 1, 1'b0});
        end else begin
          if ($urandom_range(1, 0) == 1) br_read_done = 1'b1; else br_write_done = 1'b1;
          m_idle = 1'b1;
          grant_ok = target + 2;
        end
      end
    end
  end

  // Monitor: checks grants, burst fields, completions and busy every cycle.
  initial begin
    logic [N-1:0] exp_rdy, exp_rv;
    rsp_t e; int g;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mon_en) begin
        exp_rdy = '0;
        g = -1;
        if (m_idle && cyc >= grant_ok && req_valid != '0) begin
          g = rr_pick(req_valid, m_ptr);
          exp_rdy = N'(1) << g;
        end
        chk("req_ready", DW'(req_ready), DW'(exp_rdy));
        chk("br_req", DW'(br_req), DW'(exp_rdy != '0));
        if (g >= 0) begin
          m_ptr = g; m_idle = 1'b0; hold_on = 1'b1;
          if (rq[g].size() > 0) hold_t = rq[g][0];
          bq.push_back('{g, hold_t.we});
        end
        exp_rv = '0;
        if (sq.size() > 0 && sq[0].cyc <= cyc) begin
          e = sq.pop_front();
          exp_rv = N'(1) << e.idx;
          chk("rsp_err", DW'(rsp_err), DW'(e.err));
          last_rdata = e.rdata;
          hold_on = 1'b0;
          if (!e.to) begin m_idle = 1'b1; grant_ok = cyc + 2; end
        end
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
        chk("rsp_rdata", rsp_rdata, last_rdata);
        chk("br_we", DW'(br_we), DW'(hold_on & hold_t.we));
        chk("br_addr_read", DW'(br_addr_read), hold_on ? DW'(hold_t.addr) : '0);
        chk("br_addr_write", DW'(br_addr_write), hold_on ? DW'(hold_t.addr) : '0);
        chk("br_wdata", br_wdata, hold_on ? hold_t.wdata : '0);
        chk("busy", DW'(busy), DW'(!(m_idle && cyc >= grant_ok - 1)));
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle limit, compared %0d", n_cmp);
    $fatal(1);
  end

  task automatic wait_quiet(input int bound, input string nm);
    int k;
    k = 0;
    while (!(m_idle && !hold_on && bq.size() == 0 && sq.size() == 0 &&
             rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
             rq[3].size() == 0) && k < bound) begin
      @(negedge clk); k++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (k >= bound) begin
      n_bad++;
      $display("FAIL %s: traffic still pending after %0d cycles, want drained", nm, bound);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_br_req", DW'(br_req), '0);
    chk("rst_br_addr", DW'(br_addr_read), '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);

    plan.push_back('{0, 2, 1'b1});
    for (int i = 0; i < 8; i++) plan.push_back('{0, (i == 2) ? TO : 1 + i % 3, 1'b0});
    plan.push_back('{2, 3, 1'b0});
    plan.push_back('{1, 2, 1'b0});

    rq[0].push_back(mk(1'b0, 32'h0000_1000));
    rst = 1'b0; mon_en = 1'b1; drv_en = 1'b1; rsp_en = 1'b1;
    wait_quiet(200, "single_read");

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back(mk(1'b1, 32'h0000_2000 + 32'(i * 64 + r)));
    wait_quiet(600, "all_writes");

    rq[1].push_back(mk(1'b0, 32'h0000_1100));
    rq[2].push_back(mk(1'b0, 32'h0000_1200));
    wait_quiet(300, "timeout_wrongtype");

    gap_max = 3;
    for (int t = 0; t < 40; t++) rq[$urandom_range(N - 1, 0)].push_back(mk(1'($urandom), $urandom));
    wait_quiet(5000, "random");

    mon_en = 1'b0; drv_en = 1'b0; rsp_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0010; req_we[1] = 1'b0; req_addr[AW +: AW] = 32'h0000_2000;
    k = 0;
    while (!br_req && k < 10) begin @(negedge clk); k++; end
    chk("rst_test_issue", DW'(br_req), DW'(1));
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst_busy", DW'(busy), '0);
    chk("midrst_br_we", DW'(br_we), '0);
    chk("midrst_br_addr_read", DW'(br_addr_read), '0);
    chk("midrst_br_addr_write", DW'(br_addr_write), '0);
    chk("midrst_br_wdata", br_wdata, '0);
    chk("midrst_rsp_valid", DW'(rsp_valid), '0);
    chk("midrst_rsp_rdata", rsp_rdata, '0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0101;
    req_addr[0 +: AW] = 32'h0000_3000;
    req_addr[2*AW +: AW] = 32'h0000_3200;
    @(posedge clk); #1;
    chk("post_rst_grant", DW'(req_ready), DW'(4'b0001));
    chk("post_rst_addr", DW'(br_addr_read), DW'(32'h0000_3000));
    @(negedge clk);
    req_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
